// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier shared by two round-robin requesters.
// One add/sub-and-shift step per clock; the product is held on a valid/ready output.
module booth_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod,
    output logic               out_id,
    output logic               busy
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t             state_q, state_d;
    logic               rr_q, rr_d;
    logic               id_q, id_d;
    logic               q0_q, q0_d;
    logic               out_id_q, out_id_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH:0]     m_q, m_d;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   b_sel;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               grant0, grant1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            rr_q     <= 1'b0;
            id_q     <= 1'b0;
            q0_q     <= 1'b0;
            out_id_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            m_q      <= '0;
            q_q      <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            id_q     <= id_d;
            q0_q     <= q0_d;
            out_id_q <= out_id_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            m_q      <= m_d;
            q_q      <= q_d;
            prod_q   <= prod_d;
        end
    end

    always_comb begin
        // Lone requester wins; on contention rr_q names the winner.
        grant1 = req1_valid & (~req0_valid | rr_q);
        grant0 = req0_valid & ~grant1;
        b_sel  = grant1 ? req1_b : req0_b;

        case ({q_q[0], q0_q})
            2'b10:   sum = acc_q - m_q;
            2'b01:   sum = acc_q + m_q;
            default: sum = acc_q;
        endcase

        state_d    = state_q;
        rr_d       = rr_q;
        id_d       = id_q;
        q0_d       = q0_q;
        out_id_d   = out_id_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        m_d        = m_q;
        q_d        = q_q;
        prod_d     = prod_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        unique case (state_q)
            StIdle: begin
                req0_ready = ~rst & grant0;
                req1_ready = ~rst & grant1;
                if (grant0 | grant1) begin
                    acc_d   = '0;
                    q_d     = grant1 ? req1_a : req0_a;
                    q0_d    = 1'b0;
                    m_d     = {b_sel[WIDTH-1], b_sel};
                    id_d    = grant1;
                    cnt_d   = CW'(WIDTH);
                    rr_d    = ~grant1;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Arithmetic right shift of {A,Q,q0} after the add/sub.
                acc_d = {sum[WIDTH], sum[WIDTH:1]};
                q_d   = {sum[0], q_q[WIDTH-1:1]};
                q0_d  = q_q[0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    prod_d   = {acc_d[WIDTH-1:0], q_d};
                    out_id_d = id_q;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign out_prod  = prod_q;
    assign out_id    = out_id_q;

endmodule
